// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and results.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first,
// using a single full-subtractor cell and a borrow flop.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub_if.slave io
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned MSB   = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               d_bit;
  logic               br_nxt;
  logic [WIDTH-1:0]   res_shift;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    d_bit     = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_nxt    = (~a_sr_q[0] & b_sr_q[0]) | (~a_sr_q[0] & br_q) | (b_sr_q[0] & br_q);
    res_shift = {d_bit, res_sr_q[WIDTH-1:1]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts start directly so back-to-back runs skip IDLE
        state_d = IDLE;
        busy_d  = 1'b0;
        if (io.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_sr_d  = io.a;
          b_sr_d  = io.b;
          br_d    = io.bin;
          cnt_d   = '0;
          a_msb_d = io.a[MSB];
          b_msb_d = io.b[MSB];
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_shift;
        br_d     = br_nxt;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          diff_d  = res_shift;
          bout_d  = br_nxt;
          ovf_d   = (a_msb_q != b_msb_q) && (res_shift[MSB] != a_msb_q);
          zero_d  = (res_shift == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.diff = diff_q;
  assign io.bout = bout_q;
  assign io.ovf  = ovf_q;
  assign io.zero = zero_q;

endmodule
